// File: rtl/pu_accum_pipe.sv
// NCH-channel PU: per-channel conditioning, saturating adder tree, group accumulator.
// Optional macro PU_ROUND_EN rounds the approximated field instead of truncating it.
module pu_accum_pipe #(
    parameter int XLEN = 5,
    parameter int NCH  = 4,
    parameter int CNTW = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NCH*XLEN-1:0] data_in,
    input  logic [NCH-1:0]      pass_mask,
    input  logic [CNTW-1:0]     acc_len,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     result,
    output logic                ovf
);

    function automatic logic [XLEN-1:0] approx(input logic [XLEN-1:0] x);
        logic [1:0] f;
        f = x[XLEN-2:XLEN-3];
`ifdef PU_ROUND_EN
        if (x[XLEN-4] && f != 2'b11) f = f + 2'b01;
`endif
        return {1'b1, {(XLEN-3){1'b0}}, f};
    endfunction

    logic                      en;
    logic                      out_valid_q, out_valid_d;
    logic [XLEN-1:0]           result_q, result_d;
    logic                      ovf_q, ovf_d;

    assign en        = !(out_valid_q && !out_ready);
    assign in_ready  = en && !rst;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;

    logic [NCH-1:0][XLEN-1:0] cond_d, s1_x_q;
    logic                     s1_v_q;

    always_comb begin
        cond_d = '0;
        for (int i = 0; i < NCH; i++) begin
            cond_d[i] = pass_mask[i] ? data_in[i*XLEN +: XLEN]
                                     : approx(data_in[i*XLEN +: XLEN]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            s1_x_q <= '0;
        end else if (en) begin
            s1_v_q <= in_valid;
            s1_x_q <= cond_d;
        end
    end

    // Heap-ordered tree: leaves at NCH-1.., node i sums nodes 2i+1 and 2i+2.
    logic [XLEN-1:0] tree_sum;
    logic            tree_ovf;

    always_comb begin : adder_tree
        logic [XLEN-1:0] nd [2*NCH-1];
        logic [XLEN:0]   s;
        nd       = '{default: '0};
        s        = '0;
        tree_ovf = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            nd[NCH-1+i] = s1_x_q[i];
        end
        for (int i = NCH - 2; i >= 0; i--) begin
            s        = {1'b0, nd[2*i+1]} + {1'b0, nd[2*i+2]};
            nd[i]    = s[XLEN] ? {XLEN{1'b1}} : s[XLEN-1:0];
            tree_ovf = tree_ovf | s[XLEN];
        end
        tree_sum = nd[0];
    end

    logic            s2_v_q;
    logic [XLEN-1:0] s2_sum_q;
    logic            s2_ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v_q   <= 1'b0;
            s2_sum_q <= '0;
            s2_ovf_q <= 1'b0;
        end else if (en) begin
            s2_v_q   <= s1_v_q;
            s2_sum_q <= tree_sum;
            s2_ovf_q <= tree_ovf;
        end
    end

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CNTW-1:0] len_q, len_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic            sticky_q, sticky_d;
    logic [CNTW-1:0] grp_len;
    logic [XLEN:0]   acc_sum;
    logic [XLEN-1:0] acc_sat;
    logic            beat_ovf;
    logic            last;

    always_comb begin
        cnt_d       = cnt_q;
        len_d       = len_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        grp_len     = '0;
        acc_sum     = '0;
        acc_sat     = '0;
        beat_ovf    = 1'b0;
        last        = 1'b0;
        if (en) begin
            out_valid_d = 1'b0;
            if (s2_v_q) begin
                if (cnt_q == '0) begin
                    grp_len = (acc_len == '0) ? CNTW'(1) : acc_len;
                end else begin
                    grp_len = len_q;
                end
                len_d    = grp_len;
                acc_sum  = {1'b0, acc_q} + {1'b0, s2_sum_q};
                acc_sat  = acc_sum[XLEN] ? {XLEN{1'b1}} : acc_sum[XLEN-1:0];
                beat_ovf = s2_ovf_q | acc_sum[XLEN];
                last     = ({1'b0, cnt_q} + (CNTW+1)'(1)) == {1'b0, grp_len};
                if (last) begin
                    result_d    = acc_sat;
                    ovf_d       = sticky_q | beat_ovf;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    sticky_d    = 1'b0;
                    cnt_d       = '0;
                end else begin
                    acc_d    = acc_sat;
                    sticky_d = sticky_q | beat_ovf;
                    cnt_d    = cnt_q + CNTW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            len_q       <= '0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_pu_accum_pipe.sv
// Directed bench for pu_accum_pipe with a cycle-level reference model
// (plain integer sums per group) checked on every falling edge.
module tb_pu_accum_pipe;

    localparam int XLEN = 5;
    localparam int NCH  = 4;
    localparam int CNTW = 4;
    localparam int MAXV = (1 << XLEN) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [NCH*XLEN-1:0] data_in = '0;
    logic [NCH-1:0]      pass_mask = '0;
    logic [CNTW-1:0]     acc_len = 4'd1;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [XLEN-1:0]     result;
    logic                ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pu_accum_pipe #(.XLEN(XLEN), .NCH(NCH), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .pass_mask (pass_mask),
        .acc_len   (acc_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf)
    );

    function automatic int cond(input int x, input bit raw);
        int f;
        if (raw) return x;
        f = (x >> (XLEN - 3)) % 4;
`ifdef PU_ROUND_EN
        if (((x >> (XLEN - 4)) % 2) == 1 && f < 3) f++;
`endif
        return (1 << (XLEN - 1)) + f;
    endfunction

    function automatic int beat_total(input logic [NCH*XLEN-1:0] d,
                                      input logic [NCH-1:0] m);
        int t;
        t = 0;
        for (int i = 0; i < NCH; i++) t += cond(int'(d[i*XLEN +: XLEN]), m[i]);
        return t;
    endfunction

    // Reference model: beats reach the accumulator two advancing edges after acceptance.
    bit              live = 1'b0;
    bit              exp_v = 1'b0;
    logic [XLEN-1:0] exp_res = '0;
    bit              exp_ovf = 1'b0;
    bit              pv [2] = '{1'b0, 1'b0};
    int              ps [2] = '{0, 0};
    int              g_tot = 0;
    int              g_cnt = 0;
    int              g_len = 1;

    always @(negedge clk) begin : model
        bit en;
        bit exp_rdy;
        if (live) begin
            exp_rdy = !rst && !(exp_v && !out_ready);
            n_vec++;
            if (out_valid !== exp_v || result !== exp_res ||
                ovf !== exp_ovf || in_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL cycle t=%0t: got v=%0b res=%0d ovf=%0b rdy=%0b, want v=%0b res=%0d ovf=%0b rdy=%0b",
                         $time, out_valid, result, ovf, in_ready,
                         exp_v, exp_res, exp_ovf, exp_rdy);
            end
        end
        if (rst) begin
            live    = 1'b1;
            exp_v   = 1'b0;
            exp_res = '0;
            exp_ovf = 1'b0;
            pv      = '{1'b0, 1'b0};
            ps      = '{0, 0};
            g_tot   = 0;
            g_cnt   = 0;
        end else begin
            en = !(exp_v && !out_ready);
            if (en) begin
                exp_v = 1'b0;
                if (pv[1]) begin
                    if (g_cnt == 0) g_len = (acc_len == '0) ? 1 : int'(acc_len);
                    g_tot += ps[1];
                    g_cnt++;
                    if (g_cnt == g_len) begin
                        exp_v   = 1'b1;
                        exp_res = XLEN'((g_tot > MAXV) ? MAXV : g_tot);
                        exp_ovf = (g_tot > MAXV);
                        g_tot   = 0;
                        g_cnt   = 0;
                    end
                end
                pv[1] = pv[0];
                ps[1] = ps[0];
                pv[0] = in_valid;
                ps[0] = beat_total(data_in, pass_mask);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [NCH-1:0] m, input logic [NCH*XLEN-1:0] d,
                        input logic [CNTW-1:0] len);
        bit ok;
        ok        = 1'b0;
        in_valid  = 1'b1;
        pass_mask = m;
        data_in   = d;
        acc_len   = len;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = (in_ready === 1'b1);
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_accept: in_ready stayed 0, want 1");
        end
        sync();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, input int want_res, input int want_ovf);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = (out_valid === 1'b1);
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: out_valid never rose, want 1", name);
        end else begin
            chk({name, "_res"}, int'(result), want_res);
            chk({name, "_ovf"}, int'(ovf), want_ovf);
        end
        sync();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_ready", int'(in_ready), 1);
        sync();

        // Test 1: raw sum and latency
        beat(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'd1);
        @(negedge clk);
        chk("lat_s1", int'(out_valid), 0);
        @(negedge clk);
        chk("lat_s2", int'(out_valid), 0);
        @(negedge clk);
        chk("lat_out", int'(out_valid), 1);
        chk("t1_res", int'(result), 10);
        chk("t1_ovf", int'(ovf), 0);
        sync();

        // Test 2: approximation and saturation
        beat(4'b1110, {5'd3, 5'd2, 5'd1, 5'b00100}, 4'd1);
        wait_out("t2_mix", 23, 0);
        beat(4'b0000, '0, 4'd1);
        wait_out("t2_sat", 31, 1);

        // acc_len of zero behaves as one
        beat(4'b1111, {5'd0, 5'd0, 5'd5, 5'd6}, 4'd0);
        wait_out("len0", 11, 0);

        // Test 3: three-beat group, acc_len changed mid-group
        beat(4'b1111, {5'd0, 5'd0, 5'd1, 5'd1}, 4'd3);
        beat(4'b1111, {5'd0, 5'd0, 5'd1, 5'd2}, 4'd3);
        beat(4'b1111, {5'd0, 5'd0, 5'd2, 5'd2}, 4'd3);
        acc_len = 4'd1;
        wait_out("t3_group", 9, 0);
        @(negedge clk);
        chk("t3_single_pulse", int'(out_valid), 0);
        sync();

        // Test 4: back-pressure
        out_ready = 1'b0;
        beat(4'b1111, {5'd0, 5'd0, 5'd2, 5'd3}, 4'd1);
        beat(4'b1111, {5'd0, 5'd0, 5'd3, 5'd3}, 4'd1);
        beat(4'b1111, {5'd0, 5'd0, 5'd3, 5'd4}, 4'd1);
        in_valid  = 1'b1;
        data_in   = {5'd0, 5'd0, 5'd4, 5'd4};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_res", int'(result), 5);
            chk("stall_ready", int'(in_ready), 0);
        end
        sync();
        out_ready = 1'b1;
        beat(4'b1111, {5'd0, 5'd0, 5'd4, 5'd4}, 4'd1);
        wait_out("t4_b", 6, 0);
        wait_out("t4_c", 7, 0);
        wait_out("t4_d", 8, 0);
        @(negedge clk);
        chk("t4_no_dup", int'(out_valid), 0);
        sync();

        // Test 5: reset mid-group
        beat(4'b1111, {5'd0, 5'd0, 5'd1, 5'd1}, 4'd3);
        beat(4'b1111, {5'd0, 5'd0, 5'd1, 5'd1}, 4'd3);
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_valid", int'(out_valid), 0);
        chk("t5_rst_result", int'(result), 0);
        sync();
        beat(4'b1111, {5'd0, 5'd0, 5'd3, 5'd4}, 4'd1);
        wait_out("t5_after", 7, 0);

        // Test 6: rounding bit of the approximated field
        beat(4'b1110, {5'd0, 5'd0, 5'd0, 5'b00110}, 4'd1);
`ifdef PU_ROUND_EN
        wait_out("t6_round", 18, 0);
`else
        wait_out("t6_trunc", 17, 0);
`endif

        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pu_accum_pipe.md
Name: pu_accum_pipe

Overview:
Parametrised pipelined processing unit that generalises the fixed 4-input PU to NCH channels with a per-channel approximation mode.
- Sums the conditioned channel values through a registered saturating adder tree.
- Optionally accumulates over several input beats before emitting one result.
- Has valid/ready handshakes on input and output, so it can be chained behind data sources and ahead of slower consumers in the PU datapath.

Parameters:
XLEN, 5, data width of each channel and of the result; must be >= 4.
NCH, 4, number of input channels; power of two, 2..16.
CNTW, 4, width of the accumulation-length input.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input beat valid.
in_ready  out  1  unit can accept a beat.
data_in  in  NCH*XLEN  channel i occupies data_in[i*XLEN +: XLEN].
pass_mask  in  NCH  bit i = 1: channel i is used raw; bit i = 0: channel i is approximated. Sampled with the beat.
acc_len  in  CNTW  number of beats per output group; 0 is treated as 1.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
result  out  XLEN  group sum, saturated.
ovf  out  1  saturation occurred anywhere in the group.

Behaviour:
- Reset (synchronous, active-high): the following clear to 0 on the next edge:
  - out_valid, result, ovf;
  - all stage valid bits and the accumulator;
  - the beat counter and the group-length register.
- in_ready is forced to 0 while rst is high.
- Approximation, channel i with mask bit 0: value = {1'b1, (XLEN-3) zeros, x[XLEN-2:XLEN-3]}. Example at XLEN=5: 5'b00100 -> 5'b10001 = 17.
- Stall rule: en = !(out_valid && !out_ready).
  - in_ready = en.
  - All stages advance only when en = 1.
  - A beat is accepted when in_valid && in_ready at an edge.
- Pipeline stages:
  - S1 registers the conditioned channel values plus a valid bit.
  - S2 registers the adder-tree sum: log2(NCH) levels of combinational unsigned adders, each saturating at 2^XLEN-1. A per-beat overflow flag is ORed across all levels.
  - S3 is the accumulator/output stage.
- Latency: with acc_len = 1, a beat accepted at edge t has its result visible after edge t+2, provided there is no stall.
- Grouping:
  - When the counter is 0 and S2 advances a valid beat, the group length is latched from acc_len.
  - Changes to acc_len in the middle of a group are ignored.
  - Each valid S2 beat adds (with saturation) into the accumulator and ORs into the sticky overflow.
  - On the last beat of the group: result <= sat(acc + S2 sum), ovf <= sticky | beat overflow, out_valid <= 1. The accumulator, sticky flag and counter then clear.
- Output handshake: result and ovf are held stable while out_valid && !out_ready.
  - If out_ready is high in the same cycle a group completes, the new result loads and out_valid stays 1.
  - Otherwise, when out_ready is seen, out_valid drops to 0.
- Empty pipeline: out_valid = 0, and in_ready = 1 when not in reset.
- Reset in the middle of a group discards the partial accumulation and all in-flight beats. No stale data appears in later outputs.

Optional Feature:
PU_ROUND_EN
- Defined: the approximation rounds the 2-bit field using bit x[XLEN-4], saturating the field at 2'b11. Example: 5'b00110 -> 5'b10010 = 18.
- Undefined: the field is truncated. Example: 5'b00110 -> 5'b10001 = 17.
- Raw channels are unaffected in both builds.

Test Plan:
1. XLEN=5, NCH=4, acc_len=1, pass_mask=4'b1111, channels 1,2,3,4 accepted at edge t -> after edge t+2: out_valid=1, result=10, ovf=0.
2. pass_mask=4'b1110, ch0=5'b00100, ch1..3 = 1,2,3 -> result=23, ovf=0. Then pass_mask=4'b0000 with all channels 0 -> 16*4 saturates -> result=31, ovf=1.
3. acc_len=3, three consecutive beats with sums 2,3,4 -> exactly one out_valid pulse with result=9, ovf=0; out_valid stays 0 after the first two beats.
4. out_ready=0 with out_valid=1 -> in_ready=0 and result held unchanged for 5 cycles. Then raise out_ready -> queued beats emerge in order, with no loss or duplication.
5. acc_len=3, two beats accepted, then rst high for one cycle -> out_valid=0, result=0. A following single-beat group (acc_len=1) with sum 7 -> result=7.
6. pass_mask=4'b1110, ch0=5'b00110, others 0 -> result=17 without PU_ROUND_EN; result=18 with PU_ROUND_EN defined.
